hello_cpu_0_oci_dct_packer: RTL and testbench



---
 rtl/hello_cpu_0_oci_pkg.sv | 17 +
 rtl/hello_cpu_0_oci_dct_frame_reg.sv | 53 +++++
 rtl/hello_cpu_0_oci_dct_packer.sv | 132 +++++++++++++
 tb/tb_hello_cpu_0_oci_dct_packer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hello_cpu_0_oci_pkg.sv
// Shared definitions for the OCI instruction-trace DCT path: code values,
// frame geometry and the packer FSM state type.
package hello_cpu_0_oci_pkg;

  localparam int DCT_SLOTS = 15;
  localparam int DCT_W     = 2 * DCT_SLOTS;

  localparam logic [1:0] DCT_NT  = 2'b01;
  localparam logic [1:0] DCT_TK  = 2'b10;
  localparam logic [1:0] DCT_RSV = 2'b11;

  typedef enum logic {
    FILL,
    STALL
  } dct_state_e;

endpackage

// File: rtl/hello_cpu_0_oci_dct_frame_reg.sv
// Valid/ready holding register for completed DCT frames; a load in the same
// cycle as a consume replaces the old frame without a bubble.
module hello_cpu_0_oci_dct_frame_reg
  import hello_cpu_0_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DCT_W-1:0] load_data,
  input  logic [3:0]       load_count,
  input  logic             frame_ready,
  output logic             out_free,
  output logic             frame_valid,
  output logic [DCT_W-1:0] frame_data,
  output logic [3:0]       frame_count
);

  logic             frame_valid_q, frame_valid_d;
  logic [DCT_W-1:0] frame_data_q, frame_data_d;
  logic [3:0]       frame_count_q, frame_count_d;

  always_comb begin
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    if (load) begin
      frame_valid_d = 1'b1;
      frame_data_d  = load_data;
      frame_count_d = load_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_count_q <= '0;
    end else begin
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_free    = !frame_valid_q || frame_ready;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_count = frame_count_q;

endmodule

// File: rtl/hello_cpu_0_oci_dct_packer.sv
// Packs 2-bit DCT codes into 15-slot trace frames with a valid/ready output.
// Define DCT_DROP_COUNT_EN to build the saturating drop counter.
module hello_cpu_0_oci_dct_packer
  import hello_cpu_0_oci_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trc_on,
  input  logic              dct_valid,
  input  logic [1:0]        dct_code,
  input  logic              flush,
  input  logic              test_ending,
  output logic [DCT_W-1:0]  dct_buffer,
  output logic [3:0]        dct_count,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DCT_W-1:0]  frame_data,
  output logic [3:0]        frame_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  dct_state_e       state_q, state_d;
  logic [DCT_W-1:0] buf_q, buf_d, buf_next;
  logic [3:0]       count_q, count_d, count_next;
  logic             overflow_q, overflow_d;
  logic             accept, emit, load, out_free;

  assign accept = trc_on && dct_valid && (dct_code != 2'b00);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    buf_next   = buf_q;
    count_next = count_q;
    emit       = 1'b0;
    load       = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          buf_next   = buf_q | (DCT_W'(dct_code) << {count_q, 1'b0});
          count_next = count_q + 4'd1;
        end
        emit    = (count_next == 4'(DCT_SLOTS)) ||
                  ((flush || test_ending) && (count_next != 4'd0));
        buf_d   = buf_next;
        count_d = count_next;
        if (emit) begin
          if (out_free) begin
            load    = 1'b1;
            buf_d   = '0;
            count_d = 4'd0;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // Stalled word waits for the output register; new codes are lost.
        if (accept) begin
          overflow_d = 1'b1;
        end
        if (out_free) begin
          load    = 1'b1;
          buf_d   = '0;
          count_d = 4'd0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      buf_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if ((state_q == STALL) && accept && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

  hello_cpu_0_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_data   (buf_next),
    .load_count  (count_next),
    .frame_ready (frame_ready),
    .out_free    (out_free),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_hello_cpu_0_oci_dct_packer.sv
// Self-checking bench for hello_cpu_0_oci_dct_packer: directed vectors,
// multi-cycle corner sequences and randomized traffic against a queue model.
module tb_hello_cpu_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on, dct_valid, flush, test_ending, frame_ready;
  logic [1:0]  dct_code;
  logic [29:0] dct_buffer, frame_data;
  logic [3:0]  dct_count, frame_count;
  logic        frame_valid, overflow;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  // Reference model: the partial word is a queue of codes, the output
  // register a single pending frame.
  logic [1:0]  mq[$];
  bit          m_stall, m_fv, m_ovf;
  logic [29:0] m_fd;
  logic [3:0]  m_fc;
  int          m_drop;

  typedef struct {
    logic t, v; logic [1:0] c; logic f, te, r;
    logic [3:0] e_cnt; logic [29:0] e_buf; logic e_fv;
    logic [3:0] e_fc; logic [29:0] e_fd;
  } vec_t;
  vec_t tbl[11];

  hello_cpu_0_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .dct_valid(dct_valid),
    .dct_code(dct_code), .flush(flush), .test_ending(test_ending),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_count(frame_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pack_model();
    logic [29:0] w;
    w = '0;
    foreach (mq[i]) w = w | (30'(mq[i]) << (2 * i));
    return w;
  endfunction

  function automatic logic [7:0] exp_drop();
`ifdef DCT_DROP_COUNT_EN
    return 8'(m_drop);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall = 0; m_fv = 0; m_ovf = 0; m_fd = '0; m_fc = '0; m_drop = 0;
  endtask

  task automatic model_step(input logic t, v, input logic [1:0] c, input logic f, te, r);
    bit free, acc, loaded;
    free   = !m_fv || r;
    acc    = t && v && (c != 2'b00);
    loaded = 0;
    if (!m_stall) begin
      if (acc) mq.push_back(c);
      if (mq.size() == 15 || ((f || te) && mq.size() > 0)) begin
        if (free) begin
          m_fd = pack_model(); m_fc = 4'(mq.size()); loaded = 1; mq.delete();
        end else begin
          m_stall = 1;
        end
      end
    end else begin
      if (acc) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (free) begin
        m_fd = pack_model(); m_fc = 4'(mq.size()); loaded = 1; mq.delete();
        m_stall = 0;
      end
    end
    if (loaded) m_fv = 1;
    else if (r) m_fv = 0;
  endtask

  task automatic compare_model();
    check_output("packer", {46'd0, dct_buffer, dct_count},
                 {46'd0, pack_model(), 4'(mq.size())});
    check_output("frame", {37'd0, frame_valid, frame_data, frame_count, overflow, drop_count},
                 {37'd0, m_fv, m_fd, m_fc, m_ovf, exp_drop()});
  endtask

  task automatic apply_stimulus(input logic t, v, input logic [1:0] c, input logic f, te, r);
    @(negedge clk);
    trc_on = t; dct_valid = v; dct_code = c; flush = f; test_ending = te; frame_ready = r;
    @(posedge clk);
    model_step(t, v, c, f, te, r);
    #1;
    compare_model();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    trc_on = 0; dct_valid = 0; dct_code = 0; flush = 0; test_ending = 0; frame_ready = 0;
    model_reset();
    #1;
    check_output("reset", {35'd0, dct_buffer, dct_count, frame_valid, frame_data, frame_count, overflow, drop_count},
                 80'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // trc_on, valid, code, flush, te, ready | count, buffer, fv, fcount, fdata
    tbl[0]  = '{1, 1, 2'b01, 0, 0, 1, 4'd1, 30'h1,  0, 4'd0, 30'h0};
    tbl[1]  = '{1, 1, 2'b10, 0, 0, 1, 4'd2, 30'h9,  0, 4'd0, 30'h0};
    tbl[2]  = '{1, 1, 2'b01, 0, 0, 1, 4'd3, 30'h19, 0, 4'd0, 30'h0};
    tbl[3]  = '{1, 0, 2'b00, 1, 0, 1, 4'd0, 30'h0,  1, 4'd3, 30'h19};
    tbl[4]  = '{1, 0, 2'b00, 0, 0, 1, 4'd0, 30'h0,  0, 4'd3, 30'h19};
    tbl[5]  = '{1, 0, 2'b00, 1, 0, 1, 4'd0, 30'h0,  0, 4'd3, 30'h19};
    tbl[6]  = '{1, 1, 2'b00, 1, 0, 1, 4'd0, 30'h0,  0, 4'd3, 30'h19};
    tbl[7]  = '{1, 0, 2'b00, 0, 1, 1, 4'd0, 30'h0,  0, 4'd3, 30'h19};
    tbl[8]  = '{0, 1, 2'b10, 0, 0, 1, 4'd0, 30'h0,  0, 4'd3, 30'h19};
    tbl[9]  = '{1, 1, 2'b11, 0, 0, 1, 4'd1, 30'h3,  0, 4'd3, 30'h19};
    tbl[10] = '{1, 0, 2'b00, 1, 0, 1, 4'd0, 30'h0,  1, 4'd1, 30'h3};

    reset_n = 1'b1;
    reset_dut();

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(tbl[i].t, tbl[i].v, tbl[i].c, tbl[i].f, tbl[i].te, tbl[i].r);
      check_output($sformatf("vec%0d", i),
                   {11'd0, dct_count, dct_buffer, frame_valid, frame_count, frame_data},
                   {11'd0, tbl[i].e_cnt, tbl[i].e_buf, tbl[i].e_fv, tbl[i].e_fc, tbl[i].e_fd});
    end

    // Full frame of taken codes with a ready consumer.
    for (int i = 0; i < 15; i++) apply_stimulus(1, 1, 2'b10, 0, 0, 1);
    check_output("full_frame", {41'd0, frame_valid, frame_data, frame_count, dct_count},
                 {41'd0, 1'b1, 30'h2AAAAAAA, 4'd15, 4'd0});
    apply_stimulus(1, 0, 2'b00, 0, 0, 1);
    check_output("full_frame_gone", {79'd0, frame_valid}, 80'd0);

    // Code plus flush when the word holds 14 codes.
    for (int i = 0; i < 14; i++) apply_stimulus(1, 1, 2'b01, 0, 0, 1);
    check_output("cnt14", {76'd0, dct_count}, {76'd0, 4'd14});
    apply_stimulus(1, 1, 2'b01, 1, 0, 1);
    check_output("code_flush", {71'd0, frame_valid, frame_count, dct_count},
                 {71'd0, 1'b1, 4'd15, 4'd0});
    apply_stimulus(1, 0, 2'b00, 0, 0, 1);

    // Consumer stalled: 30 codes fill two frames, 5 more are dropped.
    for (int i = 0; i < 35; i++) apply_stimulus(1, 1, 2'b10, 0, 0, 0);
    check_output("stall_state", {66'd0, frame_valid, frame_count, dct_count, overflow, drop_count},
                 {66'd0, 1'b1, 4'd15, 4'd15, 1'b1, exp_drop()});
`ifdef DCT_DROP_COUNT_EN
    check_output("drop5", {72'd0, drop_count}, {72'd0, 8'd5});
`endif
    apply_stimulus(1, 0, 2'b00, 1, 0, 1);
    check_output("stall_release", {71'd0, frame_valid, frame_count, dct_count},
                 {71'd0, 1'b1, 4'd15, 4'd0});
    apply_stimulus(1, 0, 2'b00, 0, 0, 1);
    check_output("stall_drained", {78'd0, frame_valid, overflow}, {78'd0, 1'b0, 1'b1});

    // Reset with a partial word: everything clears, nothing emerges later.
    for (int i = 0; i < 7; i++) apply_stimulus(1, 1, 2'b01, 0, 0, 1);
    check_output("cnt7", {76'd0, dct_count}, {76'd0, 4'd7});
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 2'b00, 0, 0, 1);
      check_output("post_reset_idle", {79'd0, frame_valid}, 80'd0);
    end

    // Randomized traffic with periodic consumer back-pressure.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                     2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0,
                     ((i / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
